// File: rtl/srl_dly_ctrl_pkg.sv
// Shared constants for the SRL delay controller: FSM encoding, SRL depth and field widths.
package srl_dly_ctrl_pkg;

  localparam int SRL_DEPTH = 16;
  localparam int DLY_W     = 4;
  localparam int CH_W      = 3;
  localparam int MAX_CH    = 8;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  function automatic logic ch_in_range(input logic [CH_W-1:0] ch, input int nch);
    return int'(ch) < nch;
  endfunction

endpackage

// File: rtl/srl_nx1_noparm.sv
// Fixed 16-deep addressable shift register; O taps stage A, giving A+1 CE edges of delay.
module srl_nx1_noparm
  import srl_dly_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             CE,
  input  logic [DLY_W-1:0] A,
  input  logic             I,
  output logic             O
);

  // No reset: contents are deliberately preserved across controller resets.
  logic [SRL_DEPTH-1:0] sr_reg;

  always_ff @(posedge CLK) begin
    if (CE) begin
      sr_reg <= {sr_reg[SRL_DEPTH-2:0], I};
    end
  end

  assign O = sr_reg[A];

endmodule

// File: rtl/srl_dly_ctrl.sv
// Multi-channel SRL delay line with a write/settle controller that tracks when each
// channel's output reflects its programmed delay.
module srl_dly_ctrl
  import srl_dly_ctrl_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SRLD = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE_IN,
  input  logic [NCH-1:0]   D_IN,
  output logic [NCH-1:0]   D_OUT,
  output logic [NCH-1:0]   VALID,
  input  logic             WR_STB,
  input  logic [CH_W-1:0]  WR_CH,
  input  logic [DLY_W-1:0] WR_DLY,
  input  logic [CH_W-1:0]  RD_CH,
  output logic [DLY_W-1:0] RD_DLY,
  output logic             BUSY,
  output logic             ACK,
  output logic             ERR
);

  localparam int              CNT_W    = $clog2(SRLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRLD - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CH_W-1:0]  ch_reg, ch_next;
  logic [NCH-1:0]   valid_reg, valid_next;
  logic             ack_reg, ack_next;
  logic             err_reg, err_next;
  logic             busy_reg, busy_next;
  logic             wr_load;
  logic [NCH-1:0]   wr_mask;
  logic [NCH-1:0]   ch_mask;
  logic [DLY_W-1:0] settle_dly;

  // Padded to the full 3-bit channel space so out-of-range reads return zero.
  logic [DLY_W-1:0] dly_pad [MAX_CH];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_ch
      if (gi < NCH) begin : g_used
        logic [DLY_W-1:0] dly_reg;

        always_ff @(posedge CLK) begin
          if (!RST_N) begin
            dly_reg <= '0;
          end else if (wr_load && wr_mask[gi]) begin
            dly_reg <= WR_DLY;
          end
        end

        assign dly_pad[gi] = dly_reg;

        srl_nx1_noparm u_srl (
          .CLK (CLK),
          .CE  (CE_IN),
          .A   (dly_reg),
          .I   (D_IN[gi]),
          .O   (D_OUT[gi])
        );
      end else begin : g_unused
        assign dly_pad[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    wr_mask = '0;
    ch_mask = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_mask[c] = (WR_CH == CH_W'(c));
      ch_mask[c] = (ch_reg == CH_W'(c));
    end
  end

  assign settle_dly = dly_pad[ch_reg];
  assign RD_DLY     = dly_pad[RD_CH];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_reg;
    valid_next = valid_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    wr_load    = 1'b0;

    case (state_reg)
      ST_INIT: begin
        err_next = WR_STB;
        if (CE_IN) begin
          if (cnt_reg == CNT_LAST) begin
            valid_next = '1;
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      ST_IDLE: begin
        if (WR_STB) begin
          if (ch_in_range(WR_CH, NCH)) begin
            wr_load    = 1'b1;
            cnt_next   = '0;
            ch_next    = WR_CH;
            valid_next = valid_reg & ~wr_mask;
            state_next = ST_SETTLE;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        err_next = WR_STB;
        // The write only completes once the new tap has seen dly+1 fresh samples.
        if (CE_IN) begin
          if (cnt_reg == CNT_W'(settle_dly)) begin
            valid_next = valid_reg | ch_mask;
            ack_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
      ch_reg    <= '0;
      valid_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ch_reg    <= ch_next;
      valid_reg <= valid_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
    end
  end

  assign VALID = valid_reg;
  assign BUSY  = busy_reg;
  assign ACK   = ack_reg;
  assign ERR   = err_reg;

endmodule

// File: doc/srl_dly_ctrl.md
SRL_DLY_CTRL -- requirements
Module: srl_dly_ctrl

Interface
REQ-001 Parameter NCH, default 8, number of delay channels (1..8).
REQ-002 Parameter SRLD, default 16, physical shift-register depth; fixed at 16.
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 CE_IN  input  1  global shift enable for all channels.
REQ-006 D_IN  input  NCH  per-channel serial data in.
REQ-007 D_OUT  output  NCH  per-channel delayed data out.
REQ-008 VALID  output  NCH  per-channel flag; high = D_OUT reflects the current delay setting.
REQ-009 WR_STB  input  1  single-cycle delay-write strobe.
REQ-010 WR_CH  input  3  target channel index for the write.
REQ-011 WR_DLY  input  4  new delay code; the delay is WR_DLY+1 CE cycles.
REQ-012 RD_CH  input  3  readback channel select.
REQ-013 RD_DLY  output  4  delay code of channel RD_CH.
REQ-014 BUSY  output  1  high while the block is in INIT or SETTLE.
REQ-015 ACK  output  1  one-cycle pulse when a write has settled.
REQ-016 ERR  output  1  one-cycle pulse when a write is rejected.

Function
REQ-017 Each channel SHALL satisfy D_OUT[c] = D_IN[c] delayed by dly[c]+1 CE_IN-qualified edges; the shift register advances only when CE_IN=1.
REQ-018 RD_DLY SHALL be combinational dly[RD_CH]; it reads 0 for RD_CH>=NCH.
REQ-019 The FSM SHALL have three states: INIT, IDLE and SETTLE.
REQ-020 INIT: a 4-bit counter counts CE_IN edges; on the edge where CE_IN=1 and cnt=15, the FSM SHALL set all VALID bits to 1 and go to IDLE. No ACK is generated.
REQ-021 IDLE, WR_STB=1 with WR_CH<NCH: on the same edge, dly[WR_CH]<=WR_DLY, VALID[WR_CH]<=0, cnt<=0, and the latched channel <= WR_CH; the FSM goes to SETTLE.
REQ-022 SETTLE: cnt SHALL increment on each CE_IN=1 edge. On the edge where CE_IN=1 and cnt=dly[ch], the FSM SHALL set VALID[ch]<=1 and ACK<=1, then return to IDLE. Settling therefore takes dly+1 CE edges.
REQ-023 With CE_IN held low, SETTLE and INIT SHALL hold indefinitely; cnt holds its value.
REQ-024 A write whose value equals the current dly SHALL still run the full SETTLE sequence.
REQ-025 WR_STB in INIT or SETTLE, or with WR_CH>=NCH, SHALL be ignored: no state change and no register change, and ERR pulses on the next cycle.
REQ-026 Only the written channel SHALL change its VALID bit; the other channels keep shifting undisturbed.
REQ-027 BUSY SHALL be registered: high in INIT and SETTLE, low in IDLE.

Reset
REQ-028 With RST_N=0 at a clock edge: all dly=0, VALID=0, ACK=0, ERR=0, cnt=0, and state=INIT, so BUSY=1 from the next cycle.
REQ-029 Reset during SETTLE SHALL abort the write with no ACK; all channels re-enter INIT.
REQ-030 Reset SHALL NOT clear the shift-register contents. VALID=0 marks them untrusted until INIT completes.

Structure
REQ-031 The state encoding (INIT, IDLE, SETTLE) and the SRL depth constant 16 SHALL live in a shared constants include.
REQ-032 Each channel SHALL instantiate srl_nx1_noparm, with CE=CE_IN, A=dly[c], I=D_IN[c] and O=D_OUT[c].
REQ-033 The FSM, counter, dly registers and flags SHALL be in this module; no other sub-modules are used.

Verification
REQ-034 Release reset, CE_IN=1 continuously -> BUSY=1 for 16 cycles, then VALID=0xFF and BUSY=0; no ACK.
REQ-035 Write ch2, WR_DLY=4, CE_IN=1 -> VALID[2]=0 the cycle after the strobe, ACK exactly 5 cycles after the strobe edge, VALID[2]=1; a 1-cycle pulse on D_IN[2] then appears on D_OUT[2] 5 edges later; RD_CH=2 gives RD_DLY=4.
REQ-036 Write ch0, WR_DLY=3, with CE_IN toggling 1,0,1,0,... -> ACK after 4 CE-high edges (8 clocks), and cnt holds during CE_IN=0.
REQ-037 WR_STB during SETTLE, and WR_STB during INIT -> ERR pulse, dly registers unchanged, the in-progress ACK timing unaffected.
REQ-038 Assert RST_N=0 mid-SETTLE of ch5 -> no ACK, VALID=0x00, dly[5]=0, INIT re-runs for 16 CE cycles.
REQ-039 NCH=6, write WR_CH=7 -> ERR pulse, BUSY stays 0, and VALID and all dly values unchanged.
